// File: rtl/atm_timer_pkg.sv
// Shared types and default constants for the ATM session-timeout timer.
package atm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WARN    = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam int DEF_TIMEOUT_TICKS = 60;
    localparam int DEF_WARN_TICKS    = 10;

endpackage

// File: rtl/slow_tick_detect.sv
// Rising-edge detector for the divider's slow clock, sampled as data in the clk_in domain.
module slow_tick_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic slow_clk,
    output logic rise,
    output logic tick
);

    logic slow_q;

    // slow_q resets high so a slow_clk already high at reset release is not seen as an edge
    assign rise = slow_clk & ~slow_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            slow_q <= 1'b1;
            tick   <= 1'b0;
        end else begin
            slow_q <= slow_clk;
            tick   <= rise;
        end
    end

endmodule

// File: rtl/atm_session_timer.sv
// Session countdown for the ATM controller: counts slow-clock edges down from a
// reload value, flags a warning window and then expiry until acknowledged.
module atm_session_timer
    import atm_timer_pkg::*;
#(
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int WARN_TICKS    = DEF_WARN_TICKS,
    parameter int CNT_W         = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             kick,
    input  logic             cancel,
    input  logic             ack,
    output logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             warning,
    output logic             expired
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_TICKS);

    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS >= (2 ** CNT_W) || WARN_TICKS < 0 ||
        WARN_TICKS >= TIMEOUT_TICKS) begin : g_bad_params
        $error("atm_session_timer: illegal TIMEOUT_TICKS/WARN_TICKS for CNT_W");
    end

    timer_state_t     state;
    timer_state_t     state_d;
    logic [CNT_W-1:0] rem_d;
    logic [CNT_W-1:0] dec;
    logic             rise;

    slow_tick_detect u_tick (
        .clk_in   (clk_in),
        .reset    (reset),
        .slow_clk (slow_clk),
        .rise     (rise),
        .tick     (tick)
    );

    // Saturating decrement keeps remaining from wrapping below zero
    assign dec = (remaining == '0) ? '0 : remaining - CNT_W'(1);

    always_comb begin
        state_d = state;
        rem_d   = remaining;
        case (state)
            IDLE: begin
                rem_d = '0;
                if (!cancel && start) begin
                    state_d = RUN;
                    rem_d   = RELOAD;
                end
            end
            RUN, WARN: begin
                if (cancel) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (start || kick) begin
                    // a reload wins over an edge arriving in the same cycle
                    state_d = RUN;
                    rem_d   = RELOAD;
                end else if (rise) begin
                    rem_d = dec;
                    if (dec == '0)
                        state_d = EXPIRED;
                    else if (dec <= WARN_C)
                        state_d = WARN;
                    else
                        state_d = RUN;
                end
            end
            EXPIRED: begin
                rem_d = '0;
                if (ack || cancel)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with remaining
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            warning   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_d;
            remaining <= rem_d;
            busy      <= (state_d != IDLE);
            warning   <= (state_d == WARN);
            expired   <= (state_d == EXPIRED);
        end
    end

endmodule

// File: tb/tb_atm_session_timer.sv
// Directed table-driven bench for atm_session_timer with TIMEOUT_TICKS=5, WARN_TICKS=2.
module tb_atm_session_timer;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       slow_clk = 1'b1;
    logic       start = 1'b0;
    logic       kick = 1'b0;
    logic       cancel = 1'b0;
    logic       ack = 1'b0;
    logic       tick;
    logic [7:0] remaining;
    logic       busy;
    logic       warning;
    logic       expired;

    int checks = 0;
    int passed = 0;

    atm_session_timer #(
        .TIMEOUT_TICKS (5),
        .WARN_TICKS    (2),
        .CNT_W         (8)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .start     (start),
        .kick      (kick),
        .cancel    (cancel),
        .ack       (ack),
        .tick      (tick),
        .remaining (remaining),
        .busy      (busy),
        .warning   (warning),
        .expired   (expired)
    );

    always #5 clk_in = ~clk_in;

    // One row: hold slow/rst for n cycles, pulse inputs on the last cycle, then check outputs.
    typedef struct {
        int   n;
        bit   slow;
        bit   rst;
        bit   st;
        bit   kk;
        bit   cn;
        bit   ak;
        bit   t;
        int   rem;
        bit   b;
        bit   w;
        bit   e;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input int n, input bit slow, input bit rst,
                       input bit st, input bit kk, input bit cn, input bit ak,
                       input bit t, input int rem, input bit b, input bit w, input bit e);
        vec_t v;
        v.name = name; v.n = n; v.slow = slow; v.rst = rst;
        v.st = st; v.kk = kk; v.cn = cn; v.ak = ak;
        v.t = t; v.rem = rem; v.b = b; v.w = w; v.e = e;
        vecs.push_back(v);
    endtask

    // One full slow-clock period starting with a rising edge, outputs settling to (rem,w,e)
    task automatic add_edge(input string name, input int rem, input bit b, input bit w, input bit e);
        add(name, 1, 1, 0, 0, 0, 0, 0, 1, rem, b, w, e);
        add(name, 3, 1, 0, 0, 0, 0, 0, 0, rem, b, w, e);
        add(name, 4, 0, 0, 0, 0, 0, 0, 0, rem, b, w, e);
    endtask

    task automatic check(input string name, input int idx, input bit t, input int rem,
                         input bit b, input bit w, input bit e);
        logic [11:0] got;
        logic [11:0] exp_v;
        got   = {tick, remaining, busy, warning, expired};
        exp_v = {t, 8'(rem), b, w, e};
        checks++;
        if (got === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s (row %0d): tick=%b rem=%0d busy=%b warn=%b exp=%b, wanted tick=%b rem=%0d busy=%b warn=%b exp=%b",
                     name, idx, tick, remaining, busy, warning, expired, t, rem, b, w, e);
        end
    endtask

    task automatic cycles(input int n, input bit slow);
        for (int c = 0; c < n; c++) begin
            slow_clk = slow;
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        // reset with slow_clk high: no spurious tick, first tick one cycle after next rise
        add("reset_hold",   3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("no_spurious",  4, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("idle_low",     4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("first_tick",   1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        add("idle_high",    3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        // full countdown 5,4,3,2,1,0
        add("start",        1, 0, 0, 1, 0, 0, 0,  0, 5, 1, 0, 0);
        add("run5",         3, 0, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        add_edge("cnt4", 4, 1, 0, 0);
        add_edge("cnt3", 3, 1, 0, 0);
        add_edge("cnt2_warn", 2, 1, 1, 0);
        add_edge("cnt1_warn", 1, 1, 1, 0);
        add("expire",       1, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
        add("exp_hold",     3, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
        // expiry handshake: start/kick/edges ignored until ack
        add("exp_start_ign",1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 1);
        add("exp_hold2",    2, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
        add("exp_kick_ign", 1, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1);
        add("exp_edge_ign", 1, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
        add("ack",          1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        add("idle_after",   2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("idle_low2",    4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("restart_edge", 1, 1, 0, 1, 0, 0, 0,  1, 5, 1, 0, 0);
        add("run5b",        3, 1, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        add("run5c",        4, 0, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        // kick coinciding with an edge in WARN
        add_edge("k_cnt4", 4, 1, 0, 0);
        add_edge("k_cnt3", 3, 1, 0, 0);
        add_edge("k_cnt2", 2, 1, 1, 0);
        add("kick_collide", 1, 1, 0, 0, 1, 0, 0,  1, 5, 1, 0, 0);
        add("after_kick",   3, 1, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        add("after_kick2",  4, 0, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        add("edge_not_cnt", 1, 1, 0, 0, 0, 0, 0,  1, 4, 1, 0, 0);
        add("run4",         3, 1, 0, 0, 0, 0, 0,  0, 4, 1, 0, 0);
        // cancel beats kick
        add("cancel_kick",  1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0);
        add("idle_cancel",  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("idle_edge",    1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        // mid-session reset in WARN with remaining 1
        add("m_start",      1, 1, 0, 1, 0, 0, 0,  0, 5, 1, 0, 0);
        add("m_run",        2, 1, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        add("m_run_low",    4, 0, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0);
        add_edge("m_cnt4", 4, 1, 0, 0);
        add_edge("m_cnt3", 3, 1, 0, 0);
        add_edge("m_cnt2", 2, 1, 1, 0);
        add("m_cnt1",       1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0);
        add("m_cnt1_hold",  3, 1, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
        add("mid_reset",    1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("post_reset",   3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("no_expire",    1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        add("no_expire2",   3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                slow_clk = vecs[i].slow;
                reset    = vecs[i].rst;
                start    = (c == vecs[i].n - 1) ? vecs[i].st : 1'b0;
                kick     = (c == vecs[i].n - 1) ? vecs[i].kk : 1'b0;
                cancel   = (c == vecs[i].n - 1) ? vecs[i].cn : 1'b0;
                ack      = (c == vecs[i].n - 1) ? vecs[i].ak : 1'b0;
                @(posedge clk_in);
                #1;
            end
            start = 1'b0; kick = 1'b0; cancel = 1'b0; ack = 1'b0;
            check(vecs[i].name, i, vecs[i].t, vecs[i].rem, vecs[i].b, vecs[i].w, vecs[i].e);
        end

        // standalone reset-state check with slow_clk high
        reset = 1'b1;
        cycles(2, 1'b1);
        check("reset_state", -1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cycles(2, 1'b1);
        check("reset_release", -2, 0, 0, 0, 0, 0);

        // standalone expired-wait check: start, then wait out five slow-clock periods
        start = 1'b1;
        cycles(1, 1'b1);
        start = 1'b0;
        check("wait_start", -3, 0, 5, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycles(4, 1'b0);
            cycles(4, 1'b1);
        end
        check("wait_expired", -4, 0, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
